// File: rtl/wbc_irq_latch_if.sv
// Wishbone register-slave bus bundle for wbc_irq_latch.
// The master drives the address, data, cycle, strobe and write enable signals.
// The slave returns read data and a one-cycle acknowledge.
interface wbc_irq_latch_if;
    logic [1:0]  wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i,
        output wb_dat_i,
        output wb_cyc_i,
        output wb_stb_i,
        output wb_we_i,
        input  wb_dat_o,
        input  wb_ack_o
    );

    modport slave (
        input  wb_adr_i,
        input  wb_dat_i,
        input  wb_cyc_i,
        input  wb_stb_i,
        input  wb_we_i,
        output wb_dat_o,
        output wb_ack_o
    );
endinterface

// File: rtl/wbc_irq_latch.sv
// wbc_irq_latch: interrupt request front end for N peripheral sources.
// Each source is either rising-edge latched or passed through as a level.
// It is then gated by a software enable mask and registered onto ireq.
// Mask, pending and raw state are reachable through a 4-word Wishbone slave:
//   0 ENA (RW), 1 PEND (R, write-1-clear on edge bits), 2 RAW (R), 3 reserved.
// Optional build macro WBC_IRQ_SYNC_EN adds a two-flop synchroniser on src.
//
// Bus handshake: a transfer is offered while wb_cyc_i & wb_stb_i are high.
// The slave accepts it on the edge where wb_ack_o is low, and raises wb_ack_o
// for exactly one cycle on that same edge. The register write and the wb_dat_o
// load also happen on that edge. A strobe held high is therefore
// acknowledged on alternate cycles.
module wbc_irq_latch #(
    parameter int           N    = 1,
    parameter logic [N-1:0] EDGE = {N{1'b1}}
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wbc_irq_latch_if.slave       bus,
    input  logic [N-1:0]         src,
    output logic [N-1:0]         ireq,
    input  logic [N-1:0]         iack
);

    // Source value seen by the edge/level logic (optionally synchronised).
    logic [N-1:0] s;

`ifdef WBC_IRQ_SYNC_EN
    logic [N-1:0] sync_1;
    logic [N-1:0] sync_2;

    // Two-flop synchroniser for asynchronous peripheral lines.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= src;
            sync_2 <= sync_1;
        end
    end

    assign s = sync_2;
`else
    assign s = src;
`endif

    logic [N-1:0] prev;
    logic [N-1:0] pend;
    logic [N-1:0] ena;
    logic [N-1:0] pend_next;

    logic         bus_hit;
    logic         reg_wr;
    logic         pend_w1c;
    logic [15:0]  rd_data;

    // Upper data bits beyond N carry no register state.
    logic         unused_dat;
    assign unused_dat = ^bus.wb_dat_i;

    assign bus_hit  = bus.wb_cyc_i & bus.wb_stb_i & ~bus.wb_ack_o;
    assign reg_wr   = bus_hit & bus.wb_we_i;
    assign pend_w1c = reg_wr & (bus.wb_adr_i == 2'd1);

    // Read mux; bits at and above N read as zero.
    always_comb begin
        rd_data = 16'h0000;
        case (bus.wb_adr_i)
            2'd0:    rd_data = 16'(ena);
            2'd1:    rd_data = 16'(pend);
            2'd2:    rd_data = 16'(s);
            default: rd_data = 16'h0000;
        endcase
    end

    // Next pending state: edge bits set on rise (set wins over clears), level bits follow s.
    always_comb begin
        pend_next = pend;
        for (int i = 0; i < N; i++) begin
            if (EDGE[i]) begin
                if (s[i] & ~prev[i]) begin
                    pend_next[i] = 1'b1;
                end else if (iack[i] | (pend_w1c & bus.wb_dat_i[i])) begin
                    pend_next[i] = 1'b0;
                end
            end else begin
                pend_next[i] = s[i];
            end
        end
    end

    // Bus acknowledge and read-data register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            bus.wb_ack_o <= 1'b0;
            bus.wb_dat_o <= 16'h0000;
        end else begin
            bus.wb_ack_o <= bus_hit;
            if (bus_hit) begin
                bus.wb_dat_o <= rd_data;
            end
        end
    end

    // Interrupt state: edge history, pending, enable mask and registered requests.
    // prev resets to all ones so lines already high at reset do not look like edges.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            prev <= '1;
            pend <= '0;
            ena  <= '0;
            ireq <= '0;
        end else begin
            prev <= s;
            pend <= pend_next;
            ireq <= pend & ena;
            if (reg_wr && (bus.wb_adr_i == 2'd0)) begin
                ena <= bus.wb_dat_i[N-1:0];
            end
        end
    end

endmodule

// File: tb/tb_wbc_irq_latch.sv
// Testbench for wbc_irq_latch with N=4, EDGE=4'b0011.
// A reference model advances once per clock edge and pushes the expected
// ireq/ack/read-data values into queues. A negedge monitor pops and compares them.
// Directed scenarios add fixed-value checks on top of the model.
module tb_wbc_irq_latch;

`ifdef WBC_IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam logic [3:0] EDGE_M = 4'b0011;
    // With the synchroniser, reset zeroes the sync flops while prev is all ones.
    // Held-high edge lines then rise two cycles after reset.
    localparam logic [15:0] PEND_AFTER_RST = (LAT != 0) ? 16'h000F : 16'h000C;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src;
    logic [3:0] iack;
    logic [3:0] ireq;

    int total = 0;
    int bad   = 0;

    wbc_irq_latch_if bus ();

    wbc_irq_latch #(.N(4), .EDGE(4'b0011)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus.slave),
        .src      (src),
        .ireq     (ireq),
        .iack     (iack)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Scoreboard queues.
    logic [3:0]  exp_ireq_q[$];
    logic        exp_ack_q[$];
    logic [16:0] exp_dat_q[$];   // {check_enable, data}

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one step per rising edge, from the register-map rules.
    logic [3:0] m_pend, m_ena, m_prev, m_ireq, m_s, m_sp0, m_sp1, m_new_pend;
    logic       m_ack, m_hit;
    logic [15:0] m_rd;

    always @(posedge clk) begin
        if (rst) begin
            m_pend = 4'h0; m_ena = 4'h0; m_prev = 4'hF; m_ireq = 4'h0;
            m_ack = 1'b0; m_sp0 = 4'h0; m_sp1 = 4'h0;
            exp_dat_q.push_back({1'b1, 16'h0000});
        end else begin
            m_s = (LAT != 0) ? m_sp1 : src;
            m_sp1 = m_sp0;
            m_sp0 = src;
            m_hit = bus.wb_cyc_i & bus.wb_stb_i & ~m_ack;
            case (bus.wb_adr_i)
                2'd0:    m_rd = {12'h000, m_ena};
                2'd1:    m_rd = {12'h000, m_pend};
                2'd2:    m_rd = {12'h000, m_s};
                default: m_rd = 16'h0000;
            endcase
            m_ireq = m_pend & m_ena;
            for (int i = 0; i < 4; i++) begin
                if (EDGE_M[i]) begin
                    if (m_s[i] && !m_prev[i])
                        m_new_pend[i] = 1'b1;
                    else if (iack[i] || (m_hit && bus.wb_we_i && bus.wb_adr_i == 2'd1 && bus.wb_dat_i[i]))
                        m_new_pend[i] = 1'b0;
                    else
                        m_new_pend[i] = m_pend[i];
                end else begin
                    m_new_pend[i] = m_s[i];
                end
            end
            m_pend = m_new_pend;
            m_prev = m_s;
            if (m_hit && bus.wb_we_i && bus.wb_adr_i == 2'd0)
                m_ena = bus.wb_dat_i[3:0];
            m_ack = m_hit;
            exp_dat_q.push_back({m_hit & ~bus.wb_we_i, m_rd});
        end
        exp_ireq_q.push_back(m_ireq);
        exp_ack_q.push_back(m_ack);
    end

    // Monitor: compare DUT outputs mid-cycle against the queued expectations.
    logic [16:0] mon_d;
    always @(negedge clk) begin
        if (exp_ireq_q.size() > 0)
            check("ireq", {12'h000, ireq}, {12'h000, exp_ireq_q.pop_front()});
        if (exp_ack_q.size() > 0)
            check("ack", {15'h0000, bus.wb_ack_o}, {15'h0000, exp_ack_q.pop_front()});
        if (exp_dat_q.size() > 0) begin
            mon_d = exp_dat_q.pop_front();
            if (mon_d[16])
                check("dat_o", bus.wb_dat_o, mon_d[15:0]);
        end
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_xfer(input logic we, input logic [1:0] adr, input logic [15:0] wdat,
                            output logic [15:0] rdat);
        logic got;
        got = 1'b0;
        rdat = 16'h0000;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
        bus.wb_adr_i = adr;  bus.wb_dat_i = wdat;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (bus.wb_ack_o) begin
                got = 1'b1;
                rdat = bus.wb_dat_o;
                break;
            end
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL ack_timeout: got no ack expected ack within 8 cycles at %0t", $time);
        end
    endtask

    task automatic bus_write(input logic [1:0] adr, input logic [15:0] wdat);
        logic [15:0] dummy;
        bus_xfer(1'b1, adr, wdat, dummy);
    endtask

    task automatic bus_read(input logic [1:0] adr, output logic [15:0] rdat);
        bus_xfer(1'b0, adr, 16'h0000, rdat);
    endtask

    logic [15:0] rd;

    initial begin
        rst = 1'b1; src = 4'hF; iack = 4'h0;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = 2'd0; bus.wb_dat_i = 16'h0000;

        // 1: reset with all sources high.
        repeat (3) tick();
        check("rst_ireq", {12'h000, ireq}, 16'h0000);
        check("rst_ack", {15'h0000, bus.wb_ack_o}, 16'h0000);
        rst = 1'b0;
        repeat (4) tick();
        check("post_rst_ireq", {12'h000, ireq}, 16'h0000);
        bus_read(2'd1, rd);
        check("pend_after_rst", rd, PEND_AFTER_RST);
        src = 4'h0;
        repeat (LAT + 2) tick();
        bus_write(2'd1, 16'h000F);
        tick();

        // 2: edge capture latency, hold and acknowledge.
        bus_write(2'd0, 16'h000F);
        src = 4'b0001;
        tick();
        src = 4'b0000;
        repeat (LAT) begin
            tick();
            check("t2_early", {15'h0000, ireq[0]}, 16'h0000);
        end
        check("t2_not_yet", {15'h0000, ireq[0]}, 16'h0000);
        tick();
        check("t2_raised", {15'h0000, ireq[0]}, 16'h0001);
        repeat (3) tick();
        check("t2_held", {15'h0000, ireq[0]}, 16'h0001);
        iack = 4'b0001;
        tick();
        iack = 4'b0000;
        check("t2_ack_still", {15'h0000, ireq[0]}, 16'h0001);
        tick();
        check("t2_ack_low", {15'h0000, ireq[0]}, 16'h0000);

        // 3: rise in the same cycle as iack keeps pend set.
        src = 4'b0010;
        tick();
        src = 4'b0000;
        repeat (LAT + 1) tick();
        check("t3_pending", {15'h0000, ireq[1]}, 16'h0001);
        src = 4'b0010;
        repeat (LAT) tick();
        iack = 4'b0010;
        tick();
        iack = 4'b0000;
        src = 4'b0000;
        repeat (3) begin
            tick();
            check("t3_kept", {15'h0000, ireq[1]}, 16'h0001);
        end
        iack = 4'b0010;
        tick();
        iack = 4'b0000;
        repeat (LAT + 2) tick();

        // 4: masking, late enable, write-1-clear.
        bus_write(2'd0, 16'h0000);
        src = 4'b0001;
        tick();
        src = 4'b0000;
        repeat (LAT + 2) tick();
        check("t4_masked", {12'h000, ireq}, 16'h0000);
        bus_read(2'd1, rd);
        check("t4_pend", rd, 16'h0001);
        bus_write(2'd0, 16'h0001);
        check("t4_ena_edge", {15'h0000, ireq[0]}, 16'h0000);
        tick();
        check("t4_ena_raise", {15'h0000, ireq[0]}, 16'h0001);
        bus_write(2'd1, 16'h0001);
        tick();
        check("t4_w1c", {15'h0000, ireq[0]}, 16'h0000);

        // 5: level source ignores iack, follows src.
        bus_write(2'd0, 16'h0004);
        src = 4'b0100;
        repeat (LAT + 2) tick();
        check("t5_level_on", {15'h0000, ireq[2]}, 16'h0001);
        iack = 4'b0100;
        tick();
        iack = 4'b0000;
        tick();
        check("t5_iack_ignored", {15'h0000, ireq[2]}, 16'h0001);
        bus_read(2'd2, rd);
        check("t5_raw_high", rd, 16'h0004);
        src = 4'b0000;
        tick();
        check("t5_drop_wait", {15'h0000, ireq[2]}, 16'h0001);
        repeat (LAT) begin
            tick();
            check("t5_drop_wait_sync", {15'h0000, ireq[2]}, 16'h0001);
        end
        tick();
        check("t5_dropped", {15'h0000, ireq[2]}, 16'h0000);
        repeat (LAT) tick();
        bus_read(2'd2, rd);
        check("t5_raw_low", rd, 16'h0000);

        // 6: continuous strobe acks on alternate cycles.
        tick();
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 2'd3;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t6_ack", {15'h0000, bus.wb_ack_o}, (i % 2 == 0) ? 16'h0001 : 16'h0000);
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        tick();

        // Random traffic against the model, including occasional mid-operation resets.
        for (int c = 0; c < 500; c++) begin
            rst  = ($urandom_range(0, 99) == 0);
            src  = 4'($urandom_range(0, 15));
            iack = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            bus.wb_cyc_i = 1'($urandom_range(0, 1));
            bus.wb_stb_i = 1'($urandom_range(0, 1));
            bus.wb_we_i  = 1'($urandom_range(0, 1));
            bus.wb_adr_i = 2'($urandom_range(0, 3));
            bus.wb_dat_i = 16'($urandom_range(0, 65535));
            tick();
        end
        rst = 1'b0; iack = 4'h0;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
